alu_share_sched: RTL and testbench

//  Scheduler owning the calculator's single shared ALU (add/sub plus iterative shift-add multiplier).
//  Two requesters contend for it: port 0 (digit-entry accumulate, acc*10+digit) and port 1 (operator/equal evaluate).

---
 rtl/alu_share_sched.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_sched.sv
// Shared-ALU scheduler: round-robin grant between two requesters, add/sub in one cycle, shift-add multiply over WIDTH cycles.
// Optional signed-overflow reporting is built when ALU_SHARE_OVF_EN is defined; otherwise rsp_ovf is tied low.
module alu_share_sched #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [2:0]              req0_op,
  input  logic signed [WIDTH-1:0] req0_a,
  input  logic signed [WIDTH-1:0] req0_b,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [2:0]              req1_op,
  input  logic signed [WIDTH-1:0] req1_a,
  input  logic signed [WIDTH-1:0] req1_b,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  output logic                    rsp_ovf,
  output logic                    busy
);

  localparam int PW = 2*WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     last_id;
  logic                     grant0, grant1;
  logic                     acc0, acc1, accept;
  logic [2:0]               op_in;
  logic [CW-1:0]            cnt;
  logic                     mul_last;

  logic [2:0]               op_p0;
  logic signed [WIDTH-1:0]  a_p0, b_p0;
  logic                     id_p0;

  logic [PW-1:0]            mcand_p1, prod_p1, prod_step;
  logic [WIDTH:0]           mplier_p1;
  logic                     neg_p1;
  logic [WIDTH-1:0]         exec_res, mul_res;

  // Magnitude in WIDTH+1 bits so the most negative value stays exact.
  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  // last_id resets to 1 so port 0 wins the first tie.
  assign grant0   = req0_valid && (!req1_valid || last_id);
  assign grant1   = req1_valid && (!req0_valid || !last_id);
  assign acc0     = req0_valid && req0_ready;
  assign acc1     = req1_valid && req1_ready;
  assign accept   = acc0 || acc1;
  assign op_in    = acc1 ? req1_op : req0_op;
  assign mul_last = (state == MUL) && (cnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (op_in == OP_MUL) ? MUL : EXEC;
      EXEC:    state_nxt = DONE;
      MUL:     if (cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state != IDLE);
    rsp_valid  = (state == DONE);
    if (!RST && state == IDLE) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
  end

  always_comb begin
    case (op_p0)
      OP_ADD:  exec_res = a_p0 + b_p0;
      OP_SUB:  exec_res = a_p0 - b_p0;
      default: exec_res = '0;
    endcase
  end

  assign prod_step = prod_p1 + (mplier_p1[0] ? mcand_p1 : '0);
  assign mul_res   = neg_p1 ? -prod_step[WIDTH-1:0] : prod_step[WIDTH-1:0];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      last_id    <= 1'b1;
      cnt        <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      if (accept) last_id <= acc1;
      cnt <= (state == MUL) ? cnt + 1'b1 : '0;
      if (state == EXEC) begin
        rsp_result <= exec_res;
        rsp_id     <= id_p0;
      end else if (mul_last) begin
        rsp_result <= mul_res;
        rsp_id     <= id_p0;
      end
    end
  end

  // p0: operand capture at accept; p1: multiplier load (cnt 0) then one shift-add per cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= op_in;
      a_p0  <= acc1 ? req1_a : req0_a;
      b_p0  <= acc1 ? req1_b : req0_b;
      id_p0 <= acc1;
    end
    if (state == MUL) begin
      if (cnt == '0) begin
        mcand_p1  <= PW'(mag(a_p0));
        mplier_p1 <= mag(b_p0);
        prod_p1   <= '0;
        neg_p1    <= a_p0[WIDTH-1] ^ b_p0[WIDTH-1];
      end else begin
        prod_p1   <= prod_step;
        mcand_p1  <= mcand_p1 << 1;
        mplier_p1 <= mplier_p1 >> 1;
      end
    end
  end

`ifdef ALU_SHARE_OVF_EN
  localparam logic [PW-1:0] HALF = PW'(1) << (WIDTH-1);

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Negative products may reach -2^(WIDTH-1); positive ones stop one short.
  function automatic logic mul_ovf(input logic [PW-1:0] m, input logic neg);
    return neg ? (m > HALF) : (m >= HALF);
  endfunction

  logic exec_ovf;

  always_comb begin
    case (op_p0)
      OP_ADD:  exec_ovf = add_ovf(a_p0, b_p0, exec_res);
      OP_SUB:  exec_ovf = sub_ovf(a_p0, b_p0, exec_res);
      default: exec_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST)               rsp_ovf <= 1'b0;
    else if (state == EXEC) rsp_ovf <= exec_ovf;
    else if (mul_last)      rsp_ovf <= mul_ovf(prod_step, neg_p1);
  end
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: each accepted request pushes its expected response and due cycle,
// a negedge monitor pops and compares on every rsp_valid pulse.
module tb_alu_share_sched;
  localparam int W = 16;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  logic                clk = 1'b0;
  logic                RST;
  logic                req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]          req0_op, req1_op;
  logic signed [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic                rsp_valid, rsp_id, rsp_ovf, busy;
  logic [W-1:0]        rsp_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;
  exp_t sb[$];

  alu_share_sched #(.WIDTH(W)) dut (
    .clk(clk), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact-arithmetic reference for one operation.
  function automatic void model(input logic [2:0] op, input logic signed [W-1:0] a, b,
                                output logic [W-1:0] r, output logic o);
    longint ea, eb, p;
    ea = longint'(a);
    eb = longint'(b);
    case (op)
      OP_ADD:  p = ea + eb;
      OP_SUB:  p = ea - eb;
      OP_MUL:  p = ea * eb;
      default: p = 0;
    endcase
    r = p[W-1:0];
`ifdef ALU_SHARE_OVF_EN
    o = (p < -32768) || (p > 32767);
`else
    o = 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id %0d result %h at cycle %0d, none expected", rsp_id, rsp_result, cyc);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_result !== e.res || rsp_ovf !== e.ovf || cyc != e.due) begin
          errors++;
          $display("FAIL rsp: got id %0d result %h ovf %0d cycle %0d, expected id %0d result %h ovf %0d cycle %0d",
                   rsp_id, rsp_result, rsp_ovf, cyc, e.id, e.res, e.ovf, e.due);
        end
      end
    end
  end

  task automatic issue(input bit port, input logic [2:0] op, input logic signed [W-1:0] a, b,
                       output int acc, output int waited);
    logic [W-1:0] r;
    logic         o;
    @(negedge clk);
    if (port) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else      begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    waited = 0;
    while (!(port ? req1_ready : req0_ready) && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL grant_timeout: port %0d ready never rose, expected grant within 100 cycles", port);
      req0_valid = 1'b0; req1_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    model(op, a, b, r, o);
    sb.push_back('{port, r, o, acc + ((op == OP_MUL) ? W + 2 : 2)});
    @(posedge clk); #1;
    if (port) begin req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom); end
    else      begin req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom); end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_result, rsp_ovf, req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy %b rsp_valid %b id %b result %h ovf %b rdy %b%b, expected all 0",
               busy, rsp_valid, rsp_id, rsp_result, rsp_ovf, req0_ready, req1_ready);
    end
    repeat (2) @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    RST = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add_port0();
    int acc, w;
    issue(1'b0, OP_ADD, 16'sd2, 16'sd3, acc, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL add_ready0_immediate: waited %0d, expected 0", w); end
    wait_drain();
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 16'd5) begin
      errors++;
      $display("FAIL add_hold: rsp_valid %b result %h, expected 0 and 0005", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_mul_port1();
    int acc, w, bad;
    issue(1'b1, OP_MUL, -16'sd3, -16'sd6, acc, w);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'sd1; req0_b = 16'sd1;
    bad = 0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk); #1;
      if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || (k <= W + 1 && rsp_valid !== 1'b0)) bad++;
    end
    req0_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy_window: %0d bad cycles, expected 0", bad);
    end
    wait_drain();
  endtask

  task automatic test_contention();
    logic [W-1:0] r;
    logic         o;
    int           acc0, acc1, n, w;
    do_reset();
    @(negedge clk);
    req0_op = OP_SUB; req0_a = 16'sd1;  req0_b = 16'sd1;  req0_valid = 1'b1;
    req1_op = OP_MUL; req1_a = -16'sd1; req1_b = -16'sd1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_grant: ready0 %b ready1 %b, expected 1 0", req0_ready, req1_ready);
    end
    acc0 = cyc;
    model(OP_SUB, 16'sd1, 16'sd1, r, o);
    sb.push_back('{1'b0, r, o, acc0 + 2});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n = 0;
    while (req1_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (cyc != acc0 + 3) begin
      errors++;
      $display("FAIL port1_grant_cycle: granted at cycle %0d, expected %0d", cyc, acc0 + 3);
    end
    acc1 = cyc;
    model(OP_MUL, -16'sd1, -16'sd1, r, o);
    sb.push_back('{1'b1, r, o, acc1 + W + 2});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_drain();
    issue(1'b1, OP_ADD, 16'sd7, -16'sd9, acc1, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL port1_alone: waited %0d, expected 0", w); end
    wait_drain();
  endtask

  task automatic test_back_to_back_mul();
    logic signed [W-1:0] ta [7] = '{16'sd128, -16'sd32768, -16'sd12, -16'sd32768, 16'sd0, -16'sd1, -16'sd256};
    logic signed [W-1:0] tb [7] = '{16'sd256, 16'sd1, 16'sd3000, -16'sd32768, -16'sd5, -16'sd32768, 16'sd128};
    int acc, w;
    for (int i = 0; i < 7; i++) issue(1'b0, OP_MUL, ta[i], tb[i], acc, w);
    wait_drain();
  endtask

  task automatic test_addsub_edges();
    logic [2:0]          to [7] = '{OP_SUB, OP_ADD, 3'b011, 3'b000, 3'b110, OP_ADD, OP_SUB};
    logic signed [W-1:0] ta [7] = '{-16'sd32768, -16'sd32768, 16'sd5, 16'sd9, 16'sd4, 16'sd32767, 16'sd0};
    logic signed [W-1:0] tb [7] = '{16'sd1, 16'sd32767, 16'sd6, 16'sd9, 16'sd4, 16'sd1, -16'sd32768};
    int acc, w;
    for (int i = 0; i < 7; i++) issue(i[0], to[i], ta[i], tb[i], acc, w);
    wait_drain();
  endtask

  task automatic test_reset_mid_mul();
    int acc, w, seen;
    issue(1'b0, OP_MUL, 16'sd123, -16'sd45, acc, w);
    repeat (6) @(negedge clk);
    #1;
    RST = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy %b rsp_valid %b rdy %b%b, expected all 0", busy, rsp_valid, req0_ready, req1_ready);
    end
    sb.delete();
    @(negedge clk);
    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL no_rsp_after_abort: %0d pulses, expected 0", seen); end
    issue(1'b0, OP_ADD, 16'sd1000, 16'sd2345, acc, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL post_abort_grant: waited %0d, expected 0", w); end
    wait_drain();
  endtask

  initial begin
    RST = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_add_port0();
    test_mul_port1();
    test_contention();
    test_back_to_back_mul();
    test_addsub_edges();
    test_reset_mid_mul();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
